// File: rtl/countdown_alarm_fsm.sv
// Countdown egg-timer core clocked by the 1 Hz second tick: load a preset, run/pause/resume
// down to zero, then ring an alarm until acknowledged or until the ring duration expires.
module countdown_alarm_fsm #(
  parameter int SIZE      = 8,
  parameter int RING_SECS = 10,
  parameter int RING_W    = 4
) (
  input  logic            rst,
  input  logic            sec_clk,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            start,
  input  logic            pause,
  input  logic            ack,
  output logic [SIZE-1:0] count,
  output logic [1:0]      state,
  output logic            running,
  output logic            alarm
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    ALARM = 2'b11
  } state_t;

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS > 0 ? RING_SECS - 1 : 0);
  localparam logic [SIZE-1:0]   ONE       = SIZE'(1);

  state_t            state_q;
  logic [SIZE-1:0]   count_q;
  logic              alarm_q;
  logic [RING_W-1:0] ring_cnt;

  // NOTE: asynchronous reset sits in the sensitivity list so outputs clear without waiting
  // for the next one-second tick; all state uses non-blocking assignments.
  always_ff @(posedge sec_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      alarm_q  <= 1'b0;
      ring_cnt <= '0;
    end else if (load) begin
      state_q  <= IDLE;
      count_q  <= load_val;
      alarm_q  <= 1'b0;
      ring_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && count_q != '0) state_q <= RUN;
        end
        RUN: begin
          if (pause) begin
            state_q <= PAUSE;
          end else if (count_q <= ONE) begin
            // Reaching zero and entering ALARM share one edge, so RUN never shows count 0.
            count_q  <= '0;
            state_q  <= ALARM;
            alarm_q  <= 1'b1;
            ring_cnt <= '0;
          end else begin
            count_q <= count_q - ONE;
          end
        end
        PAUSE: begin
          if (start) state_q <= RUN;
        end
        ALARM: begin
          if (ack || (RING_SECS != 0 && ring_cnt == RING_LAST)) begin
            state_q  <= IDLE;
            alarm_q  <= 1'b0;
            ring_cnt <= '0;
          end else begin
            ring_cnt <= ring_cnt + RING_W'(1);
          end
        end
      endcase
    end
  end

  assign count   = count_q;
  assign state   = state_q;
  assign alarm   = alarm_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_countdown_alarm_fsm.sv
// Self-checking bench for countdown_alarm_fsm: table vectors plus hand sequences, with
// expectations queued on drive and compared one edge later; a RING_SECS=0 copy runs alongside.
module tb_countdown_alarm_fsm;

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_ALARM = 2'b11;

  typedef struct packed {
    logic [7:0] cnt;
    logic [1:0] st;
    logic       alm;
  } out_t;

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       s;
    logic       p;
    logic       a;
    out_t       e;
    string      name;
  } vec_t;

  typedef struct {
    out_t  e;
    out_t  e0;
    string name;
  } exp_t;

  logic       rst, sec_clk;
  logic       load, start, pause, ack;
  logic [7:0] load_val;
  logic [7:0] count, count0;
  logic [1:0] state, state0;
  logic       running, running0, alarm, alarm0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  vec_t t_idle[$], t_count[$], t_pause[$], t_prio[$];

  countdown_alarm_fsm #(.SIZE(8), .RING_SECS(10), .RING_W(4)) dut (
    .rst(rst), .sec_clk(sec_clk), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .ack(ack), .count(count), .state(state), .running(running), .alarm(alarm)
  );

  countdown_alarm_fsm #(.SIZE(8), .RING_SECS(0), .RING_W(4)) dut0 (
    .rst(rst), .sec_clk(sec_clk), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .ack(ack), .count(count0), .state(state0), .running(running0),
    .alarm(alarm0)
  );

  initial sec_clk = 1'b0;
  always #5 sec_clk = ~sec_clk;

  function automatic out_t o(input logic [7:0] c, input logic [1:0] s, input logic a);
    out_t r;
    r.cnt = c;
    r.st  = s;
    r.alm = a;
    return r;
  endfunction

  function automatic vec_t mk(input logic ld, input logic [7:0] lv, input logic s,
                              input logic p, input logic a, input out_t e, input string nm);
    vec_t v;
    v.ld = ld; v.lv = lv; v.s = s; v.p = p; v.a = a; v.e = e; v.name = nm;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input out_t e, input out_t e0);
    check({nm, " count"},   32'(count),   32'(e.cnt));
    check({nm, " state"},   32'(state),   32'(e.st));
    check({nm, " alarm"},   32'(alarm),   32'(e.alm));
    check({nm, " running"}, 32'(running), 32'(e.st == S_RUN));
    check({nm, " count0"},  32'(count0),  32'(e0.cnt));
    check({nm, " state0"},  32'(state0),  32'(e0.st));
    check({nm, " alarm0"},  32'(alarm0),  32'(e0.alm));
  endtask

  task automatic step(input logic ld, input logic [7:0] lv, input logic s, input logic p,
                      input logic a, input out_t e, input out_t e0, input string nm);
    exp_t x;
    @(negedge sec_clk);
    load = ld; load_val = lv; start = s; pause = p; ack = a;
    sb.push_back('{e: e, e0: e0, name: nm});
    @(posedge sec_clk);
    #1;
    if (sb.size() == 0) begin
      check({nm, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check_outs(x.name, x.e, x.e0);
    end
  endtask

  task automatic apply(input vec_t v);
    step(v.ld, v.lv, v.s, v.p, v.a, v.e, v.e, v.name);
  endtask

  task automatic idle_inputs();
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, o(8'd0, S_IDLE, 1'b0), o(8'd0, S_IDLE, 1'b0), "x");
  endtask

  task automatic mid_reset(input string nm);
    #2 rst = 1'b1;
    #1 check_outs(nm, o(8'd0, S_IDLE, 1'b0), o(8'd0, S_IDLE, 1'b0));
    rst = 1'b0;
  endtask

  initial begin
    // Stimulus tables
    for (int i = 0; i < 5; i++) t_idle.push_back(mk(0, 0, 0, 0, 0, o(0, S_IDLE, 0), "idle"));

    t_count.push_back(mk(1, 3, 0, 0, 0, o(3, S_IDLE, 0),  "cd load3"));
    t_count.push_back(mk(0, 0, 1, 0, 0, o(3, S_RUN, 0),   "cd start"));
    t_count.push_back(mk(0, 0, 0, 0, 0, o(2, S_RUN, 0),   "cd 2"));
    t_count.push_back(mk(0, 0, 0, 0, 0, o(1, S_RUN, 0),   "cd 1"));
    t_count.push_back(mk(0, 0, 0, 0, 0, o(0, S_ALARM, 1), "cd alarm"));

    t_pause.push_back(mk(1, 5, 0, 0, 0, o(5, S_IDLE, 0), "pr load5"));
    t_pause.push_back(mk(0, 0, 1, 0, 0, o(5, S_RUN, 0),  "pr start"));
    t_pause.push_back(mk(0, 0, 0, 0, 0, o(4, S_RUN, 0),  "pr 4"));
    t_pause.push_back(mk(0, 0, 0, 0, 0, o(3, S_RUN, 0),  "pr 3"));
    for (int i = 0; i < 4; i++) t_pause.push_back(mk(0, 0, 0, 1, 0, o(3, S_PAUSE, 0), "pr hold"));
    t_pause.push_back(mk(0, 0, 1, 0, 0, o(3, S_RUN, 0),   "pr resume"));
    t_pause.push_back(mk(0, 0, 0, 0, 0, o(2, S_RUN, 0),   "pr 2"));
    t_pause.push_back(mk(0, 0, 0, 0, 0, o(1, S_RUN, 0),   "pr 1"));
    t_pause.push_back(mk(0, 0, 0, 0, 0, o(0, S_ALARM, 1), "pr alarm"));
    t_pause.push_back(mk(0, 0, 1, 0, 0, o(0, S_ALARM, 1), "alarm start ign"));
    t_pause.push_back(mk(0, 0, 0, 0, 1, o(0, S_IDLE, 0),  "alarm ack"));

    t_prio.push_back(mk(1, 2, 0, 0, 0, o(2, S_IDLE, 0),  "p load2"));
    t_prio.push_back(mk(0, 0, 0, 0, 1, o(2, S_IDLE, 0),  "idle ack ign"));
    t_prio.push_back(mk(0, 0, 0, 1, 0, o(2, S_IDLE, 0),  "idle pause ign"));
    t_prio.push_back(mk(0, 0, 1, 0, 0, o(2, S_RUN, 0),   "p start"));
    t_prio.push_back(mk(0, 0, 0, 0, 1, o(1, S_RUN, 0),   "run ack ign"));
    t_prio.push_back(mk(0, 0, 1, 0, 0, o(0, S_ALARM, 1), "run start ign"));
    t_prio.push_back(mk(1, 7, 0, 0, 1, o(7, S_IDLE, 0),  "load beats ack"));
    t_prio.push_back(mk(0, 0, 1, 0, 0, o(7, S_RUN, 0),   "p start7"));
    t_prio.push_back(mk(0, 0, 0, 1, 0, o(7, S_PAUSE, 0), "p pause"));
    t_prio.push_back(mk(0, 0, 0, 0, 1, o(7, S_PAUSE, 0), "pause ack ign"));
    t_prio.push_back(mk(0, 0, 1, 1, 0, o(7, S_RUN, 0),   "start beats pause"));
    t_prio.push_back(mk(0, 0, 1, 1, 0, o(7, S_PAUSE, 0), "run pause w start"));
    t_prio.push_back(mk(0, 0, 1, 0, 0, o(7, S_RUN, 0),   "p resume"));
    t_prio.push_back(mk(0, 0, 0, 0, 0, o(6, S_RUN, 0),   "p 6"));
    t_prio.push_back(mk(1, 0, 0, 0, 0, o(0, S_IDLE, 0),  "load0 in run"));
    t_prio.push_back(mk(0, 0, 1, 0, 0, o(0, S_IDLE, 0),  "start at 0"));
    t_prio.push_back(mk(0, 0, 1, 1, 0, o(0, S_IDLE, 0),  "start at 0 again"));

    rst = 1'b1; load = 1'b0; load_val = 8'd0; start = 1'b0; pause = 1'b0; ack = 1'b0;
    repeat (2) @(posedge sec_clk);
    #1 check_outs("reset", o(0, S_IDLE, 0), o(0, S_IDLE, 0));
    #2 rst = 1'b0;

    foreach (t_idle[i]) apply(t_idle[i]);
    foreach (t_count[i]) apply(t_count[i]);

    // Ring timeout: 10 alarm cycles on the default copy, endless ring on the RING_SECS=0 copy
    for (int i = 1; i <= 10; i++)
      step(0, 0, 0, 0, 0, (i < 10) ? o(0, S_ALARM, 1) : o(0, S_IDLE, 0), o(0, S_ALARM, 1),
           "ring timeout");

    foreach (t_pause[i]) apply(t_pause[i]);
    foreach (t_prio[i]) apply(t_prio[i]);

    // Full-range countdown without wrap
    step(1, 255, 0, 0, 0, o(255, S_IDLE, 0), o(255, S_IDLE, 0), "max load");
    step(0, 0, 1, 0, 0, o(255, S_RUN, 0), o(255, S_RUN, 0), "max start");
    for (int k = 254; k >= 1; k--)
      step(0, 0, 0, 0, 0, o(8'(k), S_RUN, 0), o(8'(k), S_RUN, 0), "max run");
    step(0, 0, 0, 0, 0, o(0, S_ALARM, 1), o(0, S_ALARM, 1), "max alarm");
    step(0, 0, 0, 0, 1, o(0, S_IDLE, 0), o(0, S_IDLE, 0), "max ack");

    // Ring-until-ack on the RING_SECS=0 copy for 55 edges
    step(1, 1, 0, 0, 0, o(1, S_IDLE, 0), o(1, S_IDLE, 0), "r0 load1");
    step(0, 0, 1, 0, 0, o(1, S_RUN, 0), o(1, S_RUN, 0), "r0 start");
    step(0, 0, 0, 0, 0, o(0, S_ALARM, 1), o(0, S_ALARM, 1), "r0 alarm");
    for (int i = 1; i <= 55; i++)
      step(0, 0, 0, 0, 0, (i <= 9) ? o(0, S_ALARM, 1) : o(0, S_IDLE, 0), o(0, S_ALARM, 1),
           "r0 hold");
    step(0, 0, 0, 0, 1, o(0, S_IDLE, 0), o(0, S_IDLE, 0), "r0 ack");

    // Asynchronous reset mid-countdown and mid-alarm
    step(1, 6, 0, 0, 0, o(6, S_IDLE, 0), o(6, S_IDLE, 0), "ar load6");
    step(0, 0, 1, 0, 0, o(6, S_RUN, 0), o(6, S_RUN, 0), "ar start");
    step(0, 0, 0, 0, 0, o(5, S_RUN, 0), o(5, S_RUN, 0), "ar 5");
    step(0, 0, 0, 0, 0, o(4, S_RUN, 0), o(4, S_RUN, 0), "ar 4");
    mid_reset("async rst run");
    idle_inputs();
    step(1, 1, 0, 0, 0, o(1, S_IDLE, 0), o(1, S_IDLE, 0), "ar load1");
    step(0, 0, 1, 0, 0, o(1, S_RUN, 0), o(1, S_RUN, 0), "ar start1");
    step(0, 0, 0, 0, 0, o(0, S_ALARM, 1), o(0, S_ALARM, 1), "ar alarm");
    step(0, 0, 0, 0, 0, o(0, S_ALARM, 1), o(0, S_ALARM, 1), "ar alarm2");
    mid_reset("async rst alarm");
    idle_inputs();

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_alarm_fsm.md
Name: countdown_alarm_fsm

Overview:
- Parametrised countdown egg-timer core, clocked by the 1 Hz second tick.
- A preset is loaded, then started, paused and resumed under user control. The remaining time counts down to zero, then the block rings an alarm.
- The alarm clears on acknowledge or after a programmable ring duration.
- Sits between the button/debounce logic and the display/buzzer drivers. It supersedes the free-running count-up alarm.

Parameters:
- SIZE, 8, width of the preset and of the remaining-time counter, in seconds.
- RING_SECS, 10, number of sec_clk cycles the alarm stays asserted without ack. 0 means ring until ack.
- RING_W, 4, width of the internal ring counter. Must satisfy 2**RING_W > RING_SECS.

Ports:
- rst  input  1  reset; asynchronous, active-high.
- sec_clk  input  1  clock; one rising edge per second.
- load  input  1  load load_val into the counter and go to IDLE.
- load_val  input  SIZE  preset in seconds.
- start  input  1  start, or resume from PAUSE.
- pause  input  1  freeze the countdown.
- ack  input  1  acknowledge (silence) the alarm.
- count  output  SIZE  remaining seconds (registered).
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ALARM (registered).
- running  output  1  high when state==RUN.
- alarm  output  1  high when state==ALARM (registered).

Behaviour:
- Reset is asynchronous and active-high. Reset values: count=0, state=IDLE, alarm=0, running=0, ring counter=0.
- Reset is honoured mid-countdown and mid-alarm; the block returns to the reset values immediately.
- Inputs are synchronous to sec_clk and sampled on each rising edge. They are level-sensitive.
- Input priority per edge: load > ack > start > pause.
- load, in any state: count<=load_val, state<=IDLE, alarm<=0, ring counter<=0.
- IDLE:
  - start with count!=0 -> RUN. The first decrement happens on the next edge spent in RUN, not on the start edge.
  - start with count==0 is ignored; the block stays in IDLE.
  - pause and ack are ignored.
- RUN:
  - pause -> PAUSE; count holds on that edge, with no decrement.
  - Otherwise count<=count-1.
  - When count==1 the same edge writes count=0, state<=ALARM, alarm<=1. There is no cycle with count==0 in RUN.
  - start while in RUN has no effect.
  - ack while in RUN is ignored (it only affects ALARM).
- PAUSE:
  - count holds.
  - start -> RUN; if pause is also asserted, start wins.
  - ack is ignored.
- ALARM:
  - count stays 0 and alarm stays 1.
  - The ring counter increments every edge; it is cleared on entry.
  - ack -> IDLE and alarm<=0 on that edge.
  - If RING_SECS!=0 and the ring counter == RING_SECS-1 -> IDLE and alarm<=0. Alarm is therefore high for exactly RING_SECS edges.
  - start is ignored, so a restart requires a load.
- Arithmetic:
  - count is unsigned with no wrap below 0, because a decrement never occurs at count==0.
  - load_val=0 followed by start never enters RUN.
  - A load during ALARM on the same edge as ack is handled as load, which also clears the alarm.
- Outputs:
  - running and alarm are decoded from the state register only, with no combinational path from the inputs.
  - Latency from an input to an output change is one sec_clk edge.

Test Plan:
- Reset then idle: rst pulse, no inputs for 5 edges -> count=0, state=00, alarm=0 throughout.
- Basic countdown: load_val=3 with load, then start for one edge.
  - Subsequent edges -> count 3, 2, 1, 0.
  - alarm rises on the edge where count becomes 0.
  - With RING_SECS=10 and no ack, alarm stays high 10 edges, then state=IDLE.
- Pause/resume: load 5, start, 2 edges -> count=3. Then:
  - pause for 4 edges -> count holds 3, state=10.
  - start -> RUN; alarm follows 3 edges later.
- Ack and priority:
  - In ALARM, ack on the 2nd alarm edge -> alarm=0, state=00 on the next edge.
  - load(7) and ack together in ALARM -> count=7, state=IDLE.
  - start and pause together in PAUSE -> RUN.
- Boundaries:
  - load 0 then start -> stays IDLE, alarm never asserts.
  - With SIZE=8, load 255 and run -> first decrement to 254, no wrap at the end.
  - With RING_SECS=0, alarm holds for 50+ edges until ack.
- Async reset mid-operation: assert rst between clock edges during RUN (count=4) and during ALARM -> all outputs are at their reset values before the next sec_clk edge.
